// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants for the memory-mapped GPIO peripheral.
//   - Register offsets within the 0x20-byte window (OFF_OUT .. OFF_CTRL)
//   - Width and saturation value of the trigger hit counter
//   - Window-membership helper used by the address decoder
package gpio_pkg;

    localparam int unsigned HITS_W = 8;
    localparam logic [HITS_W-1:0] HITS_MAX = '1;

    localparam logic [4:0] OFF_OUT  = 5'h00;
    localparam logic [4:0] OFF_DIR  = 5'h04;
    localparam logic [4:0] OFF_IN   = 5'h08;
    localparam logic [4:0] OFF_IEN  = 5'h0C;
    localparam logic [4:0] OFF_STAT = 5'h10;
    localparam logic [4:0] OFF_HITS = 5'h14;
    localparam logic [4:0] OFF_CAP  = 5'h18;
    localparam logic [4:0] OFF_CTRL = 5'h1C;

    // The window is 32 bytes on a 32-byte boundary, so membership is
    // an equality test on the upper 27 address bits.
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:5] == base[31:5];
    endfunction

endpackage

// File: rtl/gpio_mmio_if.sv
// gpio_mmio_if: data-bus connection between the core (master) and the GPIO
// peripheral (slave).
//   addr  : byte address             (master -> slave)
//   wdata : write data               (master -> slave)
//   we    : write strobe             (master -> slave)
//   re    : read strobe              (master -> slave)
//   rdata : read data, 1-cycle late  (slave -> master)
interface gpio_mmio_if;

    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output we, output re, input rdata);
    modport slave  (input addr, input wdata, input we, input re, output rdata);

endinterface

// File: rtl/gpio_sync.sv
// gpio_sync: two-flop synchroniser for asynchronous pin inputs, followed by a
// third flop used for rising-edge detection.
//   clk      : clock
//   rst      : synchronous active-high reset
//   i_async  : asynchronous pin inputs
//   o_sync   : synchronised pin values (2-cycle delay)
//   o_rise   : one-cycle pulse per rising edge of o_sync
module gpio_sync #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta   <= '0;
            r_sync   <= '0;
            r_sync_q <= '0;
        end else begin
            r_meta   <= i_async;
            r_sync   <= r_meta;
            r_sync_q <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_sync_q;

endmodule

// File: rtl/gpio_mmio.sv
// gpio_mmio: memory-mapped GPIO peripheral with edge interrupts and a
// write-trigger monitor.
//   clk       : clock, all logic on posedge
//   rst       : synchronous active-high reset
//   bus       : data-bus slave port (addr, wdata, we, re -> rdata)
//   gpio_in   : asynchronous pin inputs
//   gpio_out  : pin output values (OUT & DIR)
//   gpio_oe   : per-pin output enable (DIR)
//   cap_data  : wdata of the TRIG_HITS-th write to TRIG_ADDR
//   cap_valid : capture has occurred (until rst or CTRL clear)
//   irq       : level interrupt, |(STAT & IEN)
// Register map (offset from BASE_ADDR):
//   0x00 OUT rw, 0x04 DIR rw, 0x08 IN ro, 0x0C IEN rw, 0x10 STAT w1c,
//   0x14 HITS ro, 0x18 CAP ro, 0x1C CTRL wo (bit0 clears HITS/CAP/cap_valid)
module gpio_mmio
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_F000,
    parameter logic [31:0] TRIG_ADDR = 32'h0000_ABCD,
    parameter int unsigned TRIG_HITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    gpio_mmio_if.slave        bus,
    input  logic [WIDTH-1:0]  gpio_in,
    output logic [WIDTH-1:0]  gpio_out,
    output logic [WIDTH-1:0]  gpio_oe,
    output logic [31:0]       cap_data,
    output logic              cap_valid,
    output logic              irq
);

    localparam logic [HITS_W-1:0] TRIG_N = HITS_W'(TRIG_HITS);

    logic [WIDTH-1:0]  r_out;
    logic [WIDTH-1:0]  r_dir;
    logic [WIDTH-1:0]  r_ien;
    logic [WIDTH-1:0]  r_stat;
    logic [HITS_W-1:0] r_hits;
    logic [31:0]       r_cap;
    logic              r_cap_valid;
    logic [31:0]       r_rdata;

    logic [WIDTH-1:0]  w_sync;
    logic [WIDTH-1:0]  w_rise;
    logic              w_in_win;
    logic [4:0]        w_off;
    logic [WIDTH-1:0]  w_wdata;
    logic              w_wr;
    logic              w_hit;
    logic              w_clr;
    logic [HITS_W-1:0] w_hits_inc;
    logic [31:0]       w_rmux;

    gpio_sync #(.WIDTH(WIDTH)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (gpio_in),
        .o_sync  (w_sync),
        .o_rise  (w_rise)
    );

    assign w_in_win   = in_window(bus.addr, BASE_ADDR);
    assign w_off      = bus.addr[4:0];
    assign w_wdata    = bus.wdata[WIDTH-1:0];
    assign w_wr       = bus.we && w_in_win;
    // Hit detection is independent of the window decode, so a TRIG_ADDR
    // that lands on a register both writes the register and counts.
    assign w_hit      = bus.we && (bus.addr == TRIG_ADDR);
    assign w_clr      = w_wr && (w_off == OFF_CTRL) && bus.wdata[0];
    assign w_hits_inc = r_hits + HITS_W'(1);

    // Register file
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out  <= '0;
            r_dir  <= '0;
            r_ien  <= '0;
            r_stat <= '0;
        end else begin
            if (w_wr && (w_off == OFF_OUT)) r_out <= w_wdata;
            if (w_wr && (w_off == OFF_DIR)) r_dir <= w_wdata;
            if (w_wr && (w_off == OFF_IEN)) r_ien <= w_wdata;
            // New edges are OR-ed in after the clear so a coincident
            // edge keeps its flag set.
            if (w_wr && (w_off == OFF_STAT))
                r_stat <= (r_stat & ~w_wdata) | w_rise;
            else
                r_stat <= r_stat | w_rise;
        end
    end

    // Trigger counter and capture; a CTRL clear overrides a coincident hit.
    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            r_hits      <= '0;
            r_cap       <= '0;
            r_cap_valid <= 1'b0;
        end else if (w_hit && (r_hits != HITS_MAX)) begin
            r_hits <= w_hits_inc;
            if ((w_hits_inc == TRIG_N) && !r_cap_valid) begin
                r_cap       <= bus.wdata;
                r_cap_valid <= 1'b1;
            end
        end
    end

    // Read mux: unmapped offsets and out-of-window addresses return 0.
    always_comb begin
        w_rmux = '0;
        if (w_in_win) begin
            case (w_off)
                OFF_OUT:  w_rmux[WIDTH-1:0]  = r_out;
                OFF_DIR:  w_rmux[WIDTH-1:0]  = r_dir;
                OFF_IN:   w_rmux[WIDTH-1:0]  = w_sync;
                OFF_IEN:  w_rmux[WIDTH-1:0]  = r_ien;
                OFF_STAT: w_rmux[WIDTH-1:0]  = r_stat;
                OFF_HITS: w_rmux[HITS_W-1:0] = r_hits;
                OFF_CAP:  w_rmux             = r_cap;
                default:  w_rmux             = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_rdata <= '0;
        else if (bus.re)
            r_rdata <= w_rmux;
    end

    assign bus.rdata = r_rdata;
    assign gpio_out  = r_out & r_dir;
    assign gpio_oe   = r_dir;
    assign cap_data  = r_cap;
    assign cap_valid = r_cap_valid;
    assign irq       = |(r_stat & r_ien);

endmodule

// File: tb/tb_gpio_mmio.sv
// tb_gpio_mmio: self-checking bench for gpio_mmio (WIDTH=16 so that masking of
// bits above WIDTH is observable). Read expectations are queued when the read
// is issued and compared when rdata becomes valid one cycle later.
module tb_gpio_mmio;
    import gpio_pkg::*;

    localparam int unsigned W    = 16;
    localparam logic [31:0] BASE = 32'h0000_F000;
    localparam logic [31:0] TRIG = 32'h0000_ABCD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  gpio_in = '0;
    logic [W-1:0]  gpio_out;
    logic [W-1:0]  gpio_oe;
    logic [31:0]   cap_data;
    logic          cap_valid;
    logic          irq;

    gpio_mmio_if bus ();

    gpio_mmio #(
        .WIDTH     (W),
        .BASE_ADDR (BASE),
        .TRIG_ADDR (TRIG),
        .TRIG_HITS (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oe   (gpio_oe),
        .cap_data  (cap_data),
        .cap_valid (cap_valid),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic        rd_pend = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: rdata is valid one cycle after the edge that sampled re.
    always @(posedge clk) rd_pend <= bus.re;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0)
                check_eq("sb_nonempty", 32'(exp_q.size()), 32'd1);
            else
                check_eq(tag_q.pop_front(), bus.rdata, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        bus.re    = 1'b0;
        tick();
        bus.we    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bus.addr = a;
        bus.we   = 1'b0;
        bus.re   = 1'b1;
        tick();
        bus.re   = 1'b0;
    endtask

    task automatic wrrd(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        bus.re    = 1'b1;
        tick();
        bus.we    = 1'b0;
        bus.re    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.addr  = '0;
        bus.wdata = '0;
        bus.we    = 1'b0;
        bus.re    = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_eq("rst_gpio_out", 32'(gpio_out), 32'h0);
        check_eq("rst_gpio_oe", 32'(gpio_oe), 32'h0);
        check_eq("rst_cap_data", cap_data, 32'h0);
        check_eq("rst_cap_valid", 32'(cap_valid), 32'h0);
        check_eq("rst_irq", 32'(irq), 32'h0);
        check_eq("rst_rdata", bus.rdata, 32'h0);
        for (int unsigned i = 0; i < 8; i++)
            rd($sformatf("rst_rd_off%0d", i * 4), BASE + 32'(i * 4), 32'h0);

        // Output path, masking above WIDTH, out-of-window and unmapped reads
        wr(BASE + 32'(OFF_DIR), 32'h0000_00FF);
        wr(BASE + 32'(OFF_OUT), 32'h0000_A5A5);
        check_eq("gpio_oe", 32'(gpio_oe), 32'h0000_00FF);
        check_eq("gpio_out", 32'(gpio_out), 32'h0000_00A5);
        rd("rd_out", BASE + 32'(OFF_OUT), 32'h0000_A5A5);
        rd("rd_dir", BASE + 32'(OFF_DIR), 32'h0000_00FF);
        wrrd("wrrd_old", BASE + 32'(OFF_OUT), 32'hFFFF_FFFF, 32'h0000_A5A5);
        rd("rd_out_mask", BASE + 32'(OFF_OUT), 32'h0000_FFFF);
        check_eq("gpio_out_ff", 32'(gpio_out), 32'h0000_00FF);
        rd("rd_outside", 32'h0000_0000, 32'h0);
        rd("rd_unmapped", BASE + 32'h1, 32'h0);
        bus.addr = BASE + 32'(OFF_OUT);
        tick();
        check_eq("rdata_hold", bus.rdata, 32'h0);

        // Edge interrupt: STAT sets on the 3rd edge after the pin rises
        wr(BASE + 32'(OFF_IEN), 32'h0000_0001);
        gpio_in = 16'h0001;
        tick();
        tick();
        check_eq("irq_early", 32'(irq), 32'h0);
        tick();
        check_eq("irq_set", 32'(irq), 32'h1);
        rd("rd_in", BASE + 32'(OFF_IN), 32'h0000_0001);
        rd("rd_stat", BASE + 32'(OFF_STAT), 32'h0000_0001);
        wr(BASE + 32'(OFF_STAT), 32'h0000_0001);
        check_eq("irq_w1c", 32'(irq), 32'h0);
        rd("rd_stat_clr", BASE + 32'(OFF_STAT), 32'h0);

        // Edge coincident with W1C of the same bit keeps the flag
        gpio_in = '0;
        repeat (3) tick();
        gpio_in = 16'h0001;
        tick();
        tick();
        wr(BASE + 32'(OFF_STAT), 32'h0000_0001);
        check_eq("irq_edge_w1c", 32'(irq), 32'h1);
        rd("rd_stat_edge_w1c", BASE + 32'(OFF_STAT), 32'h0000_0001);
        wr(BASE + 32'(OFF_STAT), 32'h0000_0001);
        check_eq("irq_final_clr", 32'(irq), 32'h0);

        // Trigger monitor
        wr(TRIG, 32'h11);
        check_eq("cap_valid_hit1", 32'(cap_valid), 32'h0);
        wr(TRIG, 32'h22);
        check_eq("cap_valid_hit2", 32'(cap_valid), 32'h1);
        wr(TRIG, 32'h33);
        check_eq("cap_data", cap_data, 32'h22);
        rd("rd_hits3", BASE + 32'(OFF_HITS), 32'd3);
        rd("rd_cap", BASE + 32'(OFF_CAP), 32'h22);
        wr(BASE + 32'(OFF_CTRL), 32'h1);
        check_eq("ctrl_cap_valid", 32'(cap_valid), 32'h0);
        check_eq("ctrl_cap_data", cap_data, 32'h0);
        rd("rd_hits_clr", BASE + 32'(OFF_HITS), 32'd0);
        rd("rd_trig_read", TRIG, 32'h0);
        rd("rd_hits_after_re", BASE + 32'(OFF_HITS), 32'd0);

        // Saturation
        for (int unsigned i = 0; i < 300; i++)
            wr(TRIG, 32'(i));
        rd("rd_hits_sat", BASE + 32'(OFF_HITS), 32'd255);
        check_eq("cap_data_sat", cap_data, 32'd1);

        // Reset mid-sequence
        wr(BASE + 32'(OFF_CTRL), 32'h1);
        for (int unsigned i = 0; i < 50; i++)
            wr(TRIG, 32'(i + 100));
        rd("rd_hits50", BASE + 32'(OFF_HITS), 32'd50);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_cap_valid", 32'(cap_valid), 32'h0);
        check_eq("midrst_gpio_oe", 32'(gpio_oe), 32'h0);
        rd("rd_hits_midrst", BASE + 32'(OFF_HITS), 32'd0);
        rd("rd_dir_midrst", BASE + 32'(OFF_DIR), 32'd0);

        repeat (3) tick();
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
